substitui_bytes_inv: RTL and testbench



---
 rtl/substitui_bytes_inv_pkg.sv | 26 ++
 rtl/substitui_bytes_inv_sbox.sv | 9 +
 rtl/substitui_bytes_inv.sv | 50 +++++
 tb/tb_substitui_bytes_inv.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/substitui_bytes_inv_pkg.sv
// substitui_bytes_inv_pkg: shared AES widths, stage states and the inverse S-box table
package substitui_bytes_inv_pkg;
  localparam int BLOCK_W = 128;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} estado_t;
  // Entry 0 sits in the most significant byte; the forward table can live alongside.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
endpackage

// File: rtl/substitui_bytes_inv_sbox.sv
// inv_sbox: combinational byte lookup into the inverse S-box
module inv_sbox
  import substitui_bytes_inv_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  output logic [BYTE_W-1:0] y
);
  assign y = INV_SBOX[a];
endmodule

// File: rtl/substitui_bytes_inv.sv
// substitui_bytes_inv: inverse SubBytes, one 32-bit word per cycle through four shared S-boxes
module substitui_bytes_inv
  import substitui_bytes_inv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] bloco,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] saida,
  output logic               out_valid,
  input  logic               out_ready
);
  estado_t st, st_n;
  logic [BLOCK_W-1:0] buf_q;
  logic [1:0] cnt;
  logic [WORD_W-1:0] palavra, sub;
  logic aceita;
  assign palavra = cnt == 2'd0 ? buf_q[127:96] :
                   cnt == 2'd1 ? buf_q[95:64] :
                   cnt == 2'd2 ? buf_q[63:32] : buf_q[31:0];
  for (genvar i = 0; i < WORD_W / BYTE_W; i++) begin : g_sbox
    inv_sbox u_sbox (.a(palavra[BYTE_W*i +: BYTE_W]), .y(sub[BYTE_W*i +: BYTE_W]));
  end
  assign aceita = in_valid && in_ready;
  assign out_valid = st == DONE;
  assign saida = buf_q;
  // in_ready in DONE follows out_ready so a new block can enter as the old one leaves
  always_comb begin
    in_ready = st == IDLE || (st == DONE && out_ready);
    st_n = aceita ? BUSY :
           st == BUSY && cnt == 2'd3 ? DONE :
           st == DONE && out_ready ? IDLE : st;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_q <= '0;
      cnt <= '0;
    end else if (aceita) begin
      buf_q <= bloco;
      cnt <= '0;
    end else if (st == BUSY) begin
      for (int w = 0; w < BLOCK_W / WORD_W; w++)
        if (cnt == 2'(w)) buf_q[BLOCK_W-1-WORD_W*w -: WORD_W] <= sub;
      cnt <= cnt + 2'd1;
    end
endmodule

// File: tb/tb_substitui_bytes_inv.sv
// tb_substitui_bytes_inv: scoreboard bench with a GF(2^8)-arithmetic inverse S-box model
module tb_substitui_bytes_inv;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [127:0] bloco = '0;
  logic in_ready, out_valid;
  logic [127:0] saida;
  substitui_bytes_inv dut (.clk(clk), .rst_n(rst_n), .bloco(bloco), .in_valid(in_valid),
    .in_ready(in_ready), .saida(saida), .out_valid(out_valid), .out_ready(out_ready));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [127:0] exp; int acc;} item_t;
  item_t sb[$];
  int total = 0, passed = 0, last_acc = 0;
  bit prev_ov = 0;

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic fail(string nm);
    total++;
    $display("FAIL %s: timeout or unexpected event at cycle %0d", nm, cyc);
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 0;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  // Inverse S-box = field inverse (x^254) of the inverse affine transform
  function automatic logic [7:0] inv_sb(logic [7:0] x);
    logic [7:0] t = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
    logic [7:0] r = 8'h01;
    repeat (254) r = gmul(r, t);
    return r;
  endfunction
  function automatic logic [127:0] model(logic [127:0] b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_sb(b[8*k +: 8]);
    return r;
  endfunction
  function automatic logic [127:0] inv_shift_rows(logic [127:0] b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w = b[127-32*k -: 32];
      r[127-32*k -: 32] = k == 0 ? w : (w >> (8 * k)) | (w << (32 - 8 * k));
    end
    return r;
  endfunction

  task automatic send(logic [127:0] b, logic [127:0] exp);
    bit ok = 0;
    @(negedge clk);
    bloco = b;
    in_valid = 1;
    for (int k = 0; k < 50 && !ok; k++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        last_acc = cyc;
        sb.push_back('{exp, cyc});
      end else @(negedge clk);
    end
    if (!ok) fail("accept");
  endtask
  task automatic drain();
    for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) fail("drain");
  endtask

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) prev_ov = 0;
    else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) fail("spurious_out_valid");
        else check("latency", 128'(cyc - sb[0].acc), 128'd4);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) fail("unexpected_output");
        else check("data", saida, sb.pop_front().exp);
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    logic [127:0] b;
    int a1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_saida", saida, 0);
    rst_n = 1;
    send(128'h0, {4{32'h52525252}});
    in_valid = 0;
    drain();
    b = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
    send(b, 128'h00010203_04050607_08090a0b_0c0d0e0f);
    in_valid = 0;
    drain();
    // Backpressure: DONE held while a new block is offered
    out_ready = 0;
    b = {$urandom, $urandom, $urandom, $urandom};
    send(b, model(b));
    in_valid = 0;
    for (int k = 0; k < 20 && !out_valid; k++) begin @(negedge clk); #1; end
    if (!out_valid) fail("bp_wait");
    bloco = ~b;
    in_valid = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check("bp_saida", saida, model(b));
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    @(negedge clk);
    out_ready = 1;
    drain();
    send({16{8'h63}}, 128'h0);
    a1 = last_acc;
    send({16{8'h7c}}, {16{8'h01}});
    check("b2b_spacing", 128'(last_acc - a1), 128'd5);
    in_valid = 0;
    drain();
    send(128'h0, {4{32'h52525252}});
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_saida", saida, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    send(128'h0, {4{32'h52525252}});
    in_valid = 0;
    drain();
    send(inv_shift_rows(128'h50564543415253494c41544641544552),
         model(128'h505645434941525354464c4154455241));
    in_valid = 0;
    drain();
    for (int n = 0; n < 20; n++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom);
      send(b, model(b));
      in_valid = 0;
      repeat ($urandom_range(0, 6)) @(negedge clk);
      out_ready = 1;
      drain();
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
